pc_unit: RTL and testbench

//  Program counter stage directly downstream of the jump unit. Holds the 16-bit PC that

---
 rtl/pc_unit.sv | 148 ++++++++++++++
 tb/tb_pc_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter stage: holds the PC that addresses program ROM and feeds the jump unit.
// Latency: control inputs sampled at a clock edge show up on pc right after that edge.
// Backpressure: none; advance/jump/call/return/hold are decided every cycle.
//
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   inc           advance pc by one
//   pcoe, pcin    jump taken and its target
//   call, ret     push the return address on a taken jump / pop it back into pc
//   pc            current program counter (registered)
//   stack_empty   return stack holds no entries (registered)
//   stack_full    return stack holds STACK_DEPTH entries (registered)
//   stack_err     sticky overflow/underflow flag, cleared only by reset
//
// Build option: define PC_STACK_EN to include the return stack. Without it, call and
// ret are ignored and the stack status outputs are tied to empty / not full / no error.
module pc_unit #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0,
  parameter int               STACK_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             pcoe,
  input  logic [WIDTH-1:0] pcin,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_nxt;

  // Wraps modulo 2^WIDTH; no carry is reported.
  assign pc_inc = pc + WIDTH'(1);

`ifdef PC_STACK_EN

  localparam int AW  = $clog2(STACK_DEPTH);
  // One extra bit so that "full" (sp == STACK_DEPTH) is distinguishable from "empty".
  localparam int SPW = AW + 1;

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [SPW-1:0]   sp;
  logic [SPW-1:0]   sp_nxt;
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    wr_idx;
  logic             sp_empty;
  logic             sp_full;
  logic             push_en;
  logic             err_set;

  assign sp_empty = (sp == '0);
  assign sp_full  = (sp == SPW'(STACK_DEPTH));
  assign rd_idx   = AW'(sp - SPW'(1));
  assign wr_idx   = AW'(sp);

  // Priority: ret > pcoe > inc > hold. The stack read is combinational so a
  // return lands in pc on the same edge that ret is sampled.
  always_comb begin
    pc_nxt  = pc;
    sp_nxt  = sp;
    push_en = 1'b0;
    err_set = 1'b0;
    if (ret) begin
      if (sp_empty) begin
        // Underflow: keep the program moving forward rather than stalling.
        pc_nxt  = pc_inc;
        err_set = 1'b1;
      end else begin
        pc_nxt = stack_mem[rd_idx];
        sp_nxt = sp - SPW'(1);
      end
    end else if (pcoe) begin
      pc_nxt = pcin;
      if (call) begin
        if (sp_full) begin
          // Overflow: still take the jump, but the return address is lost.
          err_set = 1'b1;
        end else begin
          push_en = 1'b1;
          sp_nxt  = sp + SPW'(1);
        end
      end
    end else if (inc) begin
      pc_nxt = pc_inc;
    end
  end

  // Stack storage has no reset; entries above sp are never read.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[wr_idx] <= pc_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_VEC;
      sp          <= '0;
      stack_empty <= 1'b1;
      stack_full  <= 1'b0;
      stack_err   <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      sp          <= sp_nxt;
      // Status flags are computed from the next sp so they track sp edge-for-edge.
      stack_empty <= (sp_nxt == '0);
      stack_full  <= (sp_nxt == SPW'(STACK_DEPTH));
      stack_err   <= stack_err | err_set;
    end
  end

`else

  // call and ret have no meaning without the stack.
  logic unused_stack_ctl;
  assign unused_stack_ctl = call ^ ret;

  // Priority: pcoe > inc > hold.
  always_comb begin
    pc_nxt = pc;
    if (pcoe) begin
      pc_nxt = pcin;
    end else if (inc) begin
      pc_nxt = pc_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_VEC;
    end else begin
      pc <= pc_nxt;
    end
  end

  assign stack_empty = 1'b1;
  assign stack_full  = 1'b0;
  assign stack_err   = 1'b0;

`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes expected {pc, empty, full, err}.
// A monitor pops one entry after every clock edge or reset assertion that has one queued.
// Stack scenarios run when PC_STACK_EN is defined, the stackless scenario otherwise.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        inc = 1'b0;
  logic        pcoe = 1'b0;
  logic [15:0] pcin = 16'h0000;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [15:0] pc;
  logic        stack_empty;
  logic        stack_full;
  logic        stack_err;

  typedef struct packed {
    logic [15:0] pc;
    logic        empty;
    logic        full;
    logic        err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  logic  exp_err  = 1'b0;   // bench's own copy of the sticky error flag

  pc_unit #(.WIDTH(16), .RESET_VEC(16'h0000), .STACK_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .inc(inc), .pcoe(pcoe), .pcin(pcin),
    .call(call), .ret(ret), .pc(pc), .stack_empty(stack_empty),
    .stack_full(stack_full), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Monitor: compare 1 time unit after each clock edge or reset assertion.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{pc: pc, empty: stack_empty, full: stack_full, err: stack_err};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got pc=%h empty=%b full=%b err=%b, want pc=%h empty=%b full=%b err=%b",
                      nm, a.pc, a.empty, a.full, a.err, e.pc, e.empty, e.full, e.err);
      end
    end
  end

  // Apply one cycle of inputs at the falling edge; expectation is for the next rising edge.
  task automatic step(input string nm, input logic i_inc, input logic i_pcoe,
                      input logic [15:0] i_pcin, input logic i_call, input logic i_ret,
                      input logic [15:0] e_pc, input logic e_empty, input logic e_full);
    @(negedge clk);
    inc = i_inc; pcoe = i_pcoe; pcin = i_pcin; call = i_call; ret = i_ret;
    exp_q.push_back('{pc: e_pc, empty: e_empty, full: e_full, err: exp_err});
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  // Raise reset mid-cycle and expect the cleared state without waiting for a clock.
  task automatic do_reset(input string nm);
    @(posedge clk);
    #3;
    inc = 1'b0; pcoe = 1'b0; pcin = 16'h0000; call = 1'b0; ret = 1'b0;
    exp_err = 1'b0;
    exp_q.push_back('{pc: 16'h0000, empty: 1'b1, full: 1'b0, err: 1'b0});
    name_q.push_back(nm);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] tgt;
    do_reset("reset_init");

    // Advance from reset vector.
    step("inc1", 1, 0, 16'h0000, 0, 0, 16'h0001, 1, 0);
    step("inc2", 1, 0, 16'h0000, 0, 0, 16'h0002, 1, 0);
    step("inc3", 1, 0, 16'h0000, 0, 0, 16'h0003, 1, 0);
    do_reset("reset_midrun");
    step("hold_after_reset", 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0);

    // Wraparound and jump-over-inc priority.
    step("jump_fffe", 0, 1, 16'hFFFE, 0, 0, 16'hFFFE, 1, 0);
    step("inc_ffff",  1, 0, 16'h0000, 0, 0, 16'hFFFF, 1, 0);
    step("inc_wrap",  1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0);
    step("inc_pcoe",  1, 1, 16'h1234, 0, 0, 16'h1234, 1, 0);
    step("hold",      0, 0, 16'h0000, 0, 0, 16'h1234, 1, 0);

`ifdef PC_STACK_EN
    // Single call/return.
    step("jump_0010", 0, 1, 16'h0010, 0, 0, 16'h0010, 1, 0);
    step("call_0200", 0, 1, 16'h0200, 1, 0, 16'h0200, 0, 0);
    step("call_no_pcoe", 0, 0, 16'h0000, 1, 0, 16'h0200, 0, 0);
    step("ret_0011",  0, 0, 16'h0000, 0, 1, 16'h0011, 1, 0);

    // Eight nested calls from 1000, 1100, ... 1700 into 1100 ... 1800.
    step("jump_1000", 0, 1, 16'h1000, 0, 0, 16'h1000, 1, 0);
    for (int k = 0; k < 8; k++) begin
      tgt = 16'h1100 + 16'(k) * 16'h0100;
      step($sformatf("nest_call%0d", k), 0, 1, tgt, 1, 0, tgt, 0, (k == 7));
    end
    exp_err = 1'b1;
    step("call_overflow", 0, 1, 16'h0300, 1, 0, 16'h0300, 0, 1);
    for (int k = 7; k >= 0; k--) begin
      tgt = 16'h1001 + 16'(k) * 16'h0100;
      step($sformatf("nest_ret%0d", k), 0, 0, 16'h0000, 0, 1, tgt, (k == 0), 0);
    end

    // Underflow behaves as inc; error stays set.
    step("jump_0050", 0, 1, 16'h0050, 0, 0, 16'h0050, 1, 0);
    step("ret_empty", 0, 0, 16'h0000, 0, 1, 16'h0051, 1, 0);
    step("err_sticky", 1, 0, 16'h0000, 0, 0, 16'h0052, 1, 0);

    // ret beats pcoe in the same cycle.
    step("call_0060", 0, 1, 16'h0060, 1, 0, 16'h0060, 0, 0);
    step("ret_and_pcoe", 0, 1, 16'h0777, 1, 1, 16'h0053, 1, 0);
    do_reset("reset_clears_err");
`else
    // Without the stack: calls never push, returns are ignored.
    step("call_0400", 0, 1, 16'h0400, 1, 0, 16'h0400, 1, 0);
    step("ret_ignored", 0, 0, 16'h0000, 0, 1, 16'h0400, 1, 0);
    step("call_ret_inc", 1, 0, 16'h0000, 1, 1, 16'h0401, 1, 0);
    step("ret_pcoe", 0, 1, 16'h0500, 0, 1, 16'h0500, 1, 0);
    step("call_x9", 0, 1, 16'h0600, 1, 0, 16'h0600, 1, 0);
`endif

    step("final_hold", 0, 0, 16'h0000, 0, 0, pc_after_final(), 1, 0);
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Value the last scenario leaves in pc (before the trailing hold cycle).
  function automatic logic [15:0] pc_after_final();
`ifdef PC_STACK_EN
    return 16'h0000;
`else
    return 16'h0600;
`endif
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
